// File: rtl/sti_rx.sv
// sti_rx: far end of the STI serial link; rebuilds 16-bit words from framed bit streams.
// Define STI_RX_FILL_CHK_EN to reject 24/32-bit frames whose non-payload bits are nonzero.
module sti_rx #(
    parameter int DW     = 16,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              si_data,
    input  logic              si_valid,
    input  logic [1:0]        cfg_length,
    input  logic              cfg_msb,
    input  logic              cfg_fill,
    input  logic              cfg_low,
    input  logic              si_end,
    output logic [DW-1:0]     po_data,
    output logic              po_valid,
    output logic              po_err,
    output logic [STAT_W-1:0] rx_count,
    output logic              rx_finish
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [31:0]         frame_q, frame_d;
    logic [1:0]          len_q, len_d;
    logic                msb_q, msb_d;
    logic                fill_q, fill_d;
    logic                low_q, low_d;
    logic [DW-1:0]       po_data_q, po_data_d;
    logic                po_valid_q, po_valid_d;
    logic                po_err_q, po_err_d;
    logic [STAT_W-1:0]   rx_count_q, rx_count_d;
    logic                rx_finish_q, rx_finish_d;

    logic [1:0]          cur_len;
    logic                cur_msb;
    logic [4:0]          cur_cnt;
    logic [4:0]          last_idx;
    logic [4:0]          bit_idx;
    logic [31:0]         frame_ins;
    logic                frame_done;
    logic [15:0]         word;
    logic                fill_err;

    // The first bit of a frame is placed using the live config; later bits use the latched copy.
    always_comb begin
        cur_len    = (state_q == IDLE) ? cfg_length : len_q;
        cur_msb    = (state_q == IDLE) ? cfg_msb    : msb_q;
        cur_cnt    = (state_q == IDLE) ? 5'd0       : cnt_q;
        last_idx   = {cur_len, 3'b111};
        bit_idx    = cur_msb ? (last_idx - cur_cnt) : cur_cnt;
        frame_ins  = (state_q == IDLE) ? 32'd0 : frame_q;
        frame_ins[bit_idx] = si_data;
        frame_done = (state_q == SHIFT) && (cnt_q == last_idx);
    end

    always_comb begin
        word = frame_ins[15:0];
        unique case (len_q)
            2'b00:   word = low_q  ? {frame_ins[7:0], 8'h00} : {8'h00, frame_ins[7:0]};
            2'b01:   word = frame_ins[15:0];
            2'b10:   word = fill_q ? frame_ins[23:8]  : frame_ins[15:0];
            default: word = fill_q ? frame_ins[31:16] : frame_ins[15:0];
        endcase
    end

`ifdef STI_RX_FILL_CHK_EN
    always_comb begin
        fill_err = 1'b0;
        unique case (len_q)
            2'b10:   fill_err = fill_q ? (|frame_ins[7:0])  : (|frame_ins[23:16]);
            2'b11:   fill_err = fill_q ? (|frame_ins[15:0]) : (|frame_ins[31:16]);
            default: fill_err = 1'b0;
        endcase
    end
`else
    assign fill_err = 1'b0;
`endif

    // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        len_d       = len_q;
        msb_d       = msb_q;
        fill_d      = fill_q;
        low_d       = low_q;
        po_data_d   = po_data_q;
        po_valid_d  = 1'b0;
        po_err_d    = 1'b0;
        rx_count_d  = rx_count_q;
        rx_finish_d = rx_finish_q;

        if (!rx_finish_q) begin
            unique case (state_q)
                IDLE: begin
                    if (si_end) begin
                        rx_finish_d = 1'b1;
                    end else if (si_valid) begin
                        len_d   = cfg_length;
                        msb_d   = cfg_msb;
                        fill_d  = cfg_fill;
                        low_d   = cfg_low;
                        frame_d = frame_ins;
                        cnt_d   = 5'd1;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (!si_valid) begin
                        po_err_d = 1'b1;
                        cnt_d    = 5'd0;
                        state_d  = IDLE;
                    end else if (frame_done) begin
                        frame_d = frame_ins;
                        cnt_d   = 5'd0;
                        state_d = IDLE;
                        if (fill_err) begin
                            po_err_d = 1'b1;
                        end else begin
                            po_valid_d = 1'b1;
                            po_data_d  = word;
                            rx_count_d = rx_count_q + 1'b1;
                        end
                    end else begin
                        frame_d = frame_ins;
                        cnt_d   = cnt_q + 5'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            frame_q     <= 32'd0;
            len_q       <= 2'd0;
            msb_q       <= 1'b0;
            fill_q      <= 1'b0;
            low_q       <= 1'b0;
            po_data_q   <= '0;
            po_valid_q  <= 1'b0;
            po_err_q    <= 1'b0;
            rx_count_q  <= '0;
            rx_finish_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            len_q       <= len_d;
            msb_q       <= msb_d;
            fill_q      <= fill_d;
            low_q       <= low_d;
            po_data_q   <= po_data_d;
            po_valid_q  <= po_valid_d;
            po_err_q    <= po_err_d;
            rx_count_q  <= rx_count_d;
            rx_finish_q <= rx_finish_d;
        end
    end

    assign po_data   = po_data_q;
    assign po_valid  = po_valid_q;
    assign po_err    = po_err_q;
    assign rx_count  = rx_count_q;
    assign rx_finish = rx_finish_q;

endmodule

// File: tb/tb_sti_rx.sv
// tb_sti_rx: directed vector table plus hand-written sequences for sti_rx.
// Expected values follow STI_RX_FILL_CHK_EN when it is defined for the build.
module tb_sti_rx;

`ifdef STI_RX_FILL_CHK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int NV = 11;

    logic        clk;
    logic        reset;
    logic        si_data;
    logic        si_valid;
    logic [1:0]  cfg_length;
    logic        cfg_msb;
    logic        cfg_fill;
    logic        cfg_low;
    logic        si_end;
    logic [15:0] po_data;
    logic        po_valid;
    logic        po_err;
    logic [15:0] rx_count;
    logic        rx_finish;

    int n_checks = 0;
    int n_fail   = 0;

    sti_rx #(.DW(16), .STAT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .si_data   (si_data),
        .si_valid  (si_valid),
        .cfg_length(cfg_length),
        .cfg_msb   (cfg_msb),
        .cfg_fill  (cfg_fill),
        .cfg_low   (cfg_low),
        .si_end    (si_end),
        .po_data   (po_data),
        .po_valid  (po_valid),
        .po_err    (po_err),
        .rx_count  (rx_count),
        .rx_finish (rx_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  len;
        logic        msb;
        logic        fill;
        logic        low;
        logic [31:0] frame;
        int          nbits;      // 0 = full frame, otherwise truncate after this many bits
        logic        exp_valid;
        logic        exp_err;
        logic [15:0] exp_data;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bits after the first carry inverted cfg values, which the receiver must ignore.
    task automatic send_bits(input logic [1:0] len, input logic msb, input logic fill,
                             input logic low, input logic [31:0] frame, input int nb,
                             input int end_at);
        int n;
        n = 8 * (int'(len) + 1);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            si_valid = 1'b1;
            si_data  = msb ? frame[n-1-i] : frame[i];
            if (i == 0) begin
                cfg_length = len;  cfg_msb = msb;  cfg_fill = fill;  cfg_low = low;
            end else begin
                cfg_length = ~len; cfg_msb = ~msb; cfg_fill = ~fill; cfg_low = ~low;
            end
            if (i == end_at) si_end = 1'b1;
        end
        @(negedge clk);
        si_valid = 1'b0;
        si_data  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        int          n;
        logic [15:0] base;
        logic [15:0] stream;

        vecs[0]  = '{2'b01, 1'b1, 1'b0, 1'b0, 32'h0000A5C3, 0,  1'b1, 1'b0, 16'hA5C3, 16'd1};
        vecs[1]  = '{2'b00, 1'b0, 1'b0, 1'b1, 32'h0000003C, 0,  1'b1, 1'b0, 16'h3C00, 16'd2};
        vecs[2]  = '{2'b00, 1'b0, 1'b0, 1'b0, 32'h0000003C, 0,  1'b1, 1'b0, 16'h003C, 16'd3};
        vecs[3]  = '{2'b11, 1'b1, 1'b1, 1'b0, 32'h12340000, 0,  1'b1, 1'b0, 16'h1234, 16'd4};
        vecs[4]  = '{2'b11, 1'b1, 1'b1, 1'b0, 32'h12340001, 0,  1'(CHK == 0), 1'(CHK == 1),
                     16'h1234, 16'(5 - CHK)};
        vecs[5]  = '{2'b10, 1'b1, 1'b0, 1'b0, 32'h00BEEF00, 10, 1'b0, 1'b1, 16'h1234, 16'(5 - CHK)};
        vecs[6]  = '{2'b10, 1'b1, 1'b0, 1'b0, 32'h0000BEEF, 0,  1'b1, 1'b0, 16'hBEEF, 16'(6 - CHK)};
        vecs[7]  = '{2'b01, 1'b0, 1'b0, 1'b0, 32'h00008001, 0,  1'b1, 1'b0, 16'h8001, 16'(7 - CHK)};
        vecs[8]  = '{2'b10, 1'b0, 1'b1, 1'b0, 32'h00CAFE00, 0,  1'b1, 1'b0, 16'hCAFE, 16'(8 - CHK)};
        vecs[9]  = '{2'b11, 1'b0, 1'b0, 1'b0, 32'h0000F00D, 0,  1'b1, 1'b0, 16'hF00D, 16'(9 - CHK)};
        vecs[10] = '{2'b10, 1'b1, 1'b0, 1'b0, 32'h0001BEEF, 0,  1'(CHK == 0), 1'(CHK == 1),
                     (CHK == 1) ? 16'hF00D : 16'hBEEF, 16'(10 - CHK)};

        reset = 1'b1; si_data = 1'b0; si_valid = 1'b0; si_end = 1'b0;
        cfg_length = 2'b00; cfg_msb = 1'b0; cfg_fill = 1'b0; cfg_low = 1'b0;
        repeat (3) @(negedge clk);
        check("reset po_data",   32'(po_data),   32'h0);
        check("reset po_valid",  32'(po_valid),  32'h0);
        check("reset po_err",    32'(po_err),    32'h0);
        check("reset rx_count",  32'(rx_count),  32'h0);
        check("reset rx_finish", 32'(rx_finish), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < NV; k++) begin
            v = vecs[k];
            n = (v.nbits == 0) ? 8 * (int'(v.len) + 1) : v.nbits;
            send_bits(v.len, v.msb, v.fill, v.low, v.frame, n, -1);
            if (v.nbits != 0) @(negedge clk);
            check($sformatf("v%0d po_valid", k), 32'(po_valid), 32'(v.exp_valid));
            check($sformatf("v%0d po_err",   k), 32'(po_err),   32'(v.exp_err));
            check($sformatf("v%0d po_data",  k), 32'(po_data),  32'(v.exp_data));
            check($sformatf("v%0d rx_count", k), 32'(rx_count), 32'(v.exp_count));
            @(negedge clk);
            check($sformatf("v%0d strobes clear", k), {30'd0, po_valid, po_err}, 32'h0);
        end

        // Back-to-back 8-bit frames 0x81 then 0x7E, si_valid held high throughout.
        base   = vecs[NV-1].exp_count;
        stream = 16'h817E;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 8) begin
                check("b2b first po_valid", 32'(po_valid), 32'h1);
                check("b2b first po_data",  32'(po_data),  32'h0081);
                check("b2b first rx_count", 32'(rx_count), 32'(base + 16'd1));
            end
            if (i == 9) check("b2b first one-cycle", 32'(po_valid), 32'h0);
            si_valid = 1'b1; si_data = stream[15-i];
            cfg_length = 2'b00; cfg_msb = 1'b1; cfg_fill = 1'b0; cfg_low = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("b2b second po_valid", 32'(po_valid), 32'h1);
                check("b2b second po_data",  32'(po_data),  32'h007E);
                check("b2b second rx_count", 32'(rx_count), 32'(base + 16'd2));
            end
            si_data = 1'b1;
        end
        @(negedge clk);
        si_data = 1'b1;
        reset   = 1'b1;
        #1;
        check("midframe reset po_data",  32'(po_data),  32'h0);
        check("midframe reset rx_count", 32'(rx_count), 32'h0);
        check("midframe reset strobes",  {30'd0, po_valid, po_err}, 32'h0);
        @(negedge clk);
        si_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        send_bits(2'b01, 1'b1, 1'b0, 1'b0, 32'h0000A5C3, 16, -1);
        check("post-reset po_valid", 32'(po_valid), 32'h1);
        check("post-reset po_data",  32'(po_data),  32'hA5C3);
        check("post-reset rx_count", 32'(rx_count), 32'h1);
        @(negedge clk);

        // si_end rises in the middle of the final frame.
        send_bits(2'b00, 1'b1, 1'b0, 1'b0, 32'h00000055, 8, 3);
        check("end frame po_valid",      32'(po_valid),  32'h1);
        check("end frame po_data",       32'(po_data),   32'h0055);
        check("end frame rx_count",      32'(rx_count),  32'h2);
        check("finish not yet",          32'(rx_finish), 32'h0);
        @(negedge clk);
        check("finish set",              32'(rx_finish), 32'h1);
        send_bits(2'b00, 1'b1, 1'b0, 1'b0, 32'h000000AA, 8, -1);
        check("after finish po_valid",   32'(po_valid),  32'h0);
        check("after finish po_err",     32'(po_err),    32'h0);
        check("after finish po_data",    32'(po_data),   32'h0055);
        check("after finish rx_count",   32'(rx_count),  32'h2);
        si_end = 1'b0;
        repeat (2) @(negedge clk);
        check("finish sticky",           32'(rx_finish), 32'h1);
        check("after finish no strobe",  {30'd0, po_valid, po_err}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
